delay_arbiter: RTL

DELAY_ARBITER -- requirements
Module: delay_arbiter

---
 rtl/delay_arbiter_pkg.sv | 16 +
 rtl/delay_arbiter_rr_arbiter.sv | 33 +++
 rtl/delay_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/delay_arbiter_pkg.sv
// Shared defaults and tag types for the round-robin delay-pipeline arbiter.
package delay_arbiter_pkg;

  localparam int unsigned DEF_N_REQ   = 4;
  localparam int unsigned DEF_DATA_W  = 14;
  localparam int unsigned DEF_LATENCY = 9;
  localparam int unsigned ID_W        = $clog2(DEF_N_REQ);

  typedef logic [ID_W-1:0] id_t;

  typedef struct packed {
    logic valid;
    id_t  id;
  } tag_t;

endpackage

// File: rtl/delay_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts one past ptr and the first requester found wins.
module rr_arbiter
  import delay_arbiter_pkg::*;
#(
  parameter int unsigned N = DEF_N_REQ
) (
  input  logic [N-1:0] req,
  input  id_t          ptr,
  output logic [N-1:0] grant_c,
  output id_t          grant_id_c
);

  logic        found;
  int unsigned idx;
  logic [N-1:0] sh;

  always_comb begin
    found      = 1'b0;
    grant_id_c = '0;
    idx        = 0;
    sh         = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      idx = (32'(ptr) + i) % N;
      sh  = req >> idx;
      if (!found && sh[0]) begin
        found      = 1'b1;
        grant_id_c = ID_W'(idx);
      end
    end
    grant_c = found ? (N'(1) << grant_id_c) : '0;
  end

endmodule

// File: rtl/delay_arbiter.sv
// Shares a fixed-latency pipeline among requesters; tags each issue with its owner
// and routes each return back to that owner.
module delay_arbiter
  import delay_arbiter_pkg::*;
#(
  parameter int unsigned N_REQ   = DEF_N_REQ,
  parameter int unsigned DATA_W  = DEF_DATA_W,
  parameter int unsigned LATENCY = DEF_LATENCY
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ-1:0][DATA_W-1:0]  req_data,
  output logic [N_REQ-1:0]              req_ready,
  output logic [DATA_W-1:0]             pipe_in_data,
  output logic                          pipe_in_valid,
  input  logic [DATA_W-1:0]             pipe_out_data,
  input  logic                          pipe_out_valid,
  output logic [N_REQ-1:0]              resp_valid,
  output logic [DATA_W-1:0]             resp_data,
  output logic                          busy,
  output logic                          err_mismatch
);

  localparam int unsigned CNT_W = $clog2(LATENCY + 1);

  id_t              last_grant;
  id_t              win_id;
  logic [N_REQ-1:0] req_eff;
  logic [N_REQ-1:0] grant;
  logic             transfer;
  logic             ret;
  tag_t             tags [LATENCY];
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] settle;
  logic             armed;

  // No grants while disabled or held in reset.
  assign req_eff = req_valid & {N_REQ{enable & ~rst}};

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req        (req_eff),
    .ptr        (last_grant),
    .grant_c    (grant),
    .grant_id_c (win_id)
  );

  assign req_ready     = grant;
  assign transfer      = |grant;
  assign pipe_in_valid = transfer;
  assign pipe_in_data  = transfer ? req_data[win_id] : '0;

  // A return is only honoured when a tag says an item is due this cycle.
  assign ret        = tags[LATENCY-1].valid & pipe_out_valid;
  assign resp_valid = ret ? (N_REQ'(1) << tags[LATENCY-1].id) : '0;
  assign resp_data  = ret ? pipe_out_data : '0;
  assign busy       = inflight != '0;
  assign armed      = settle == CNT_W'(LATENCY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{valid: transfer, id: win_id};
      for (int unsigned i = 1; i < LATENCY; i++) tags[i] <= tags[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= ID_W'(N_REQ - 1);
    end else if (transfer) begin
      last_grant <= win_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({transfer, ret})
        2'b10:   inflight <= inflight + CNT_W'(1);
        2'b01:   inflight <= inflight - CNT_W'(1);
        default: inflight <= inflight;
      endcase
    end
  end

  // Stale pipeline contents may emerge for LATENCY cycles after reset; ignore them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle       <= '0;
      err_mismatch <= 1'b0;
    end else begin
      if (!armed) settle <= settle + CNT_W'(1);
      if (armed && (tags[LATENCY-1].valid != pipe_out_valid)) err_mismatch <= 1'b1;
    end
  end

endmodule
